// File: rtl/ysyx_alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE -> EXEC -> RESP).
// Define YSYX_ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module ysyx_alu_arb #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_0,
    input  logic          req_valid_1,
    output logic          req_ready_0,
    output logic          req_ready_1,
    input  logic [DW-1:0] src_a_0,
    input  logic [DW-1:0] src_a_1,
    input  logic [DW-1:0] src_b_0,
    input  logic [DW-1:0] src_b_1,
    input  logic [3:0]    func_0,
    input  logic [3:0]    func_1,
    output logic          rsp_valid_0,
    output logic          rsp_valid_1,
    input  logic          rsp_ready_0,
    input  logic          rsp_ready_1,
    output logic [DW-1:0] rsp_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_func,
    input  logic [DW-1:0] alu_result,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] result_q;
    logic [3:0]    func_q;
    logic          owner_q;
    logic          last_grant;

    logic          in_idle;
    logic          grant_any;
    logic          grant_id;
    logic          rsp_take;

    assign in_idle   = (state == IDLE);
    assign grant_any = req_valid_0 | req_valid_1;
    assign rsp_take  = owner_q ? rsp_ready_1 : rsp_ready_0;

    // A tie goes to the requester that did not win last time (round-robin) or to requester 0.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid_0 && req_valid_1) begin
`ifdef YSYX_ALU_ARB_RR_EN
            grant_id = ~last_grant;
`else
            grant_id = last_grant & 1'b0;
`endif
        end else begin
            grant_id = ~req_valid_0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            func_q     <= '0;
            owner_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state <= state_next;
            if (in_idle && grant_any) begin
                a_q        <= grant_id ? src_a_1 : src_a_0;
                b_q        <= grant_id ? src_b_1 : src_b_0;
                func_q     <= grant_id ? func_1  : func_0;
                owner_q    <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    // Control outputs are forced low while rst is high, even before the state register clears.
    assign req_ready_0 = !rst && in_idle && req_valid_0 && !grant_id;
    assign req_ready_1 = !rst && in_idle && req_valid_1 &&  grant_id;
    assign rsp_valid_0 = !rst && (state == RESP) && !owner_q;
    assign rsp_valid_1 = !rst && (state == RESP) &&  owner_q;
    assign busy        = !rst && !in_idle;
    assign alu_a       = rst ? '0 : a_q;
    assign alu_b       = rst ? '0 : b_q;
    assign alu_func    = rst ? 4'd0 : func_q;
    assign rsp_result  = result_q;

endmodule

// File: tb/tb_ysyx_alu_arb.sv
// Scoreboard bench for ysyx_alu_arb: directed vectors, expected responses queued at issue time.
// A small behavioural ALU stands in for the shared combinational unit.
module tb_ysyx_alu_arb;

    logic        clk;
    logic        rst;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] src_a_0, src_a_1, src_b_0, src_b_1;
    logic [3:0]  func_0, func_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_result;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_func;
    logic [31:0] alu_result;
    logic        busy;

    typedef struct packed {
        logic        owner;
        logic [31:0] result;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    ysyx_alu_arb #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .src_a_0(src_a_0), .src_a_1(src_a_1),
        .src_b_0(src_b_0), .src_b_1(src_b_1),
        .func_0(func_0), .func_1(func_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_result(rsp_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_result(alu_result),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = alu_a ^ alu_b;
        case (alu_func)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b1101: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic valid, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] f);
        if (id == 0) begin
            req_valid_0 = valid; src_a_0 = a; src_b_0 = b; func_0 = f;
        end else begin
            req_valid_1 = valid; src_a_1 = a; src_b_1 = b; func_1 = f;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
    endtask

    task automatic pulseReset();
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (scoreboard.size() != 0 && budget < 20) begin
            sampleCycle();
            budget++;
        end
        checkOutput("scoreboard_drained", scoreboard.size(), 0);
    endtask

    // Monitor: every response handshake is matched against the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if ((rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1)) begin
            checkOutput("rsp_valid_exclusive", {31'd0, rsp_valid_0 & rsp_valid_1}, 32'd0);
            checkOutput("rsp_expected", {31'd0, scoreboard.size() != 0}, 32'd1);
            if (scoreboard.size() != 0) begin
                e = scoreboard.pop_front();
                checkOutput("rsp_owner", {31'd0, rsp_valid_1}, {31'd0, e.owner});
                checkOutput("rsp_result", rsp_result, e.result);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants;
        int budget;
        int g;
        int k0;
        int k1;
        int order[4];
        int exp_order[4];

        rst = 1'b1;
        applyStimulus(0, 1'b1, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b0;

        sampleCycle();
        checkOutput("in_reset_req_ready_0", req_ready_0, 0);
        checkOutput("in_reset_busy", busy, 0);
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        nextCycle();
        rst = 1'b0;
        sampleCycle();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rsp_valid_0", rsp_valid_0, 0);
        checkOutput("reset_rsp_valid_1", rsp_valid_1, 0);
        checkOutput("reset_alu_a", alu_a, 0);
        checkOutput("reset_alu_b", alu_b, 0);
        checkOutput("reset_alu_func", alu_func, 0);
        checkOutput("reset_rsp_result", rsp_result, 0);

        $display("[TB] ADD from requester 0");
        nextCycle();
        applyStimulus(0, 1'b1, 32'd5, 32'd7, 4'b0000);
        rsp_ready_0 = 1'b1;
        sampleCycle();
        checkOutput("add_req_ready_0", req_ready_0, 1);
        checkOutput("add_req_ready_1", req_ready_1, 0);
        scoreboard.push_back('{owner: 1'b0, result: 32'd12});
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        sampleCycle();
        checkOutput("add_t1_busy", busy, 1);
        checkOutput("add_t1_rsp_valid_0", rsp_valid_0, 0);
        checkOutput("add_t1_alu_a", alu_a, 32'd5);
        checkOutput("add_t1_alu_b", alu_b, 32'd7);
        checkOutput("add_t1_req_ready_0", req_ready_0, 0);
        nextCycle();
        sampleCycle();
        checkOutput("add_t2_rsp_valid_0", rsp_valid_0, 1);
        checkOutput("add_t2_rsp_result", rsp_result, 32'd12);
        nextCycle();
        sampleCycle();
        checkOutput("add_t3_busy", busy, 0);

        $display("[TB] SRA from requester 1");
        nextCycle();
        applyStimulus(1, 1'b1, 32'h8000_0000, 32'd4, 4'b1101);
        rsp_ready_1 = 1'b1;
        sampleCycle();
        checkOutput("sra_req_ready_1", req_ready_1, 1);
        checkOutput("sra_req_ready_0", req_ready_0, 0);
        scoreboard.push_back('{owner: 1'b1, result: 32'hF800_0000});
        nextCycle();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        nextCycle();
        sampleCycle();
        checkOutput("sra_t2_rsp_valid_1", rsp_valid_1, 1);
        checkOutput("sra_t2_rsp_valid_0", rsp_valid_0, 0);
        checkOutput("sra_t2_rsp_result", rsp_result, 32'hF800_0000);
        nextCycle();
        sampleCycle();
        checkOutput("sra_t3_busy", busy, 0);

        $display("[TB] both requesters valid continuously");
        pulseReset();
        k0 = 0;
        k1 = 0;
        applyStimulus(0, 1'b1, 32'd1, 32'd10, 4'b0000);
        applyStimulus(1, 1'b1, 32'd100, 32'd0, 4'b0001);
`ifdef YSYX_ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
        scoreboard.push_back('{owner: 1'b0, result: 32'd11});
        scoreboard.push_back('{owner: 1'b1, result: 32'd100});
        scoreboard.push_back('{owner: 1'b0, result: 32'd12});
        scoreboard.push_back('{owner: 1'b1, result: 32'd99});
`else
        exp_order = '{0, 0, 0, 0};
        scoreboard.push_back('{owner: 1'b0, result: 32'd11});
        scoreboard.push_back('{owner: 1'b0, result: 32'd12});
        scoreboard.push_back('{owner: 1'b0, result: 32'd13});
        scoreboard.push_back('{owner: 1'b0, result: 32'd14});
`endif
        order = '{0, 0, 0, 0};
        grants = 0;
        budget = 0;
        while (grants < 4 && budget < 60) begin
            sampleCycle();
            g = -1;
            if (req_ready_0 || req_ready_1) begin
                checkOutput("tie_ready_exclusive", {31'd0, req_ready_0 & req_ready_1}, 32'd0);
                g = req_ready_0 ? 0 : 1;
                order[grants] = g;
            end
            nextCycle();
            if (g == 0) begin
                k0++;
                applyStimulus(0, 1'b1, 32'(k0 + 1), 32'd10, 4'b0000);
            end else if (g == 1) begin
                k1++;
                applyStimulus(1, 1'b1, 32'd100, 32'(k1), 4'b0001);
            end
            if (g >= 0) grants++;
            budget++;
        end
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("tie_grant_count", grants, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("tie_grant_order_%0d", i), order[i], exp_order[i]);
        end
        drain();

        $display("[TB] response back-pressure on requester 0");
        pulseReset();
        applyStimulus(0, 1'b1, 32'd3, 32'd4, 4'b0000);
        applyStimulus(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0110);
        rsp_ready_0 = 1'b0;
        rsp_ready_1 = 1'b1;
        sampleCycle();
        checkOutput("stall_req_ready_0", req_ready_0, 1);
        checkOutput("stall_req_ready_1", req_ready_1, 0);
        scoreboard.push_back('{owner: 1'b0, result: 32'd7});
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        sampleCycle();
        checkOutput("stall_exec_req_ready_1", req_ready_1, 0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            sampleCycle();
            checkOutput($sformatf("stall_hold_rsp_valid_0_%0d", i), rsp_valid_0, 1);
            checkOutput($sformatf("stall_hold_rsp_result_%0d", i), rsp_result, 32'd7);
            checkOutput($sformatf("stall_hold_req_ready_1_%0d", i), req_ready_1, 0);
        end
        nextCycle();
        rsp_ready_0 = 1'b1;
        sampleCycle();
        checkOutput("stall_release_req_ready_1", req_ready_1, 0);
        nextCycle();
        rsp_ready_0 = 1'b0;
        sampleCycle();
        checkOutput("stall_after_req_ready_1", req_ready_1, 1);
        scoreboard.push_back('{owner: 1'b1, result: 32'h0000_00FF});
        nextCycle();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        drain();

        $display("[TB] reset while executing");
        nextCycle();
        applyStimulus(0, 1'b1, 32'd1, 32'd1, 4'b0000);
        rsp_ready_0 = 1'b1;
        sampleCycle();
        checkOutput("abort_req_ready_0", req_ready_0, 1);
        nextCycle();
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 4'd0);
        applyStimulus(1, 1'b1, 32'd20, 32'd22, 4'b0000);
        rsp_ready_1 = 1'b1;
        rst = 1'b1;
        sampleCycle();
        checkOutput("abort_in_reset_busy", busy, 0);
        checkOutput("abort_in_reset_req_ready_1", req_ready_1, 0);
        nextCycle();
        rst = 1'b0;
        sampleCycle();
        checkOutput("abort_after_busy", busy, 0);
        checkOutput("abort_after_rsp_valid_0", rsp_valid_0, 0);
        checkOutput("abort_after_req_ready_1", req_ready_1, 1);
        scoreboard.push_back('{owner: 1'b1, result: 32'd42});
        nextCycle();
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 4'd0);
        drain();

        nextCycle();
        nextCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_alu_arb.md
YSYX_ALU_ARB -- requirements
Module: ysyx_alu_arb

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning), in this order:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid_0 / req_valid_1  in  1  requester n has an operation.
- req_ready_0 / req_ready_1  out  1  arbiter accepts requester n this cycle.
- src_a_0 / src_a_1  in  DW  operand A of requester n.
- src_b_0 / src_b_1  in  DW  operand B of requester n.
- func_0 / func_1  in  4  ALU op code of requester n, passed through unmodified.
- rsp_valid_0 / rsp_valid_1  out  1  result for requester n is available.
- rsp_ready_0 / rsp_ready_1  in  1  requester n takes the result.
- rsp_result  out  DW  result, shared by both requesters.
- alu_a / alu_b  out  DW  operands to the shared combinational ALU.
- alu_func  out  4  op code to the shared ALU.
- alu_result  in  DW  combinational ALU output.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-005 In IDLE, SHALL grant exactly one valid requester and assert only that requester's req_ready, combinationally from req_valid; no valid requester means no ready and stay in IDLE.
REQ-006 On accept (valid & ready), SHALL latch src_a, src_b, func and an owner id, then go to EXEC.
REQ-007 In EXEC, SHALL drive alu_a/alu_b/alu_func from the latched registers, capture alu_result into the result register at the clock edge, and go to RESP.
REQ-008 In RESP, SHALL assert rsp_valid of the owner only, drive rsp_result from the result register, and hold both stable until the owner's rsp_ready is sampled high; then go to IDLE.
REQ-009 Timing: accept in cycle T; rsp_valid goes high in cycle T+2.
REQ-010 The next accept SHALL occur no earlier than T+3; maximum throughput is one operation per 3 cycles.
REQ-011 req_ready_0/1 SHALL be 0 in EXEC and RESP; requests arriving then wait without being lost.
REQ-012 The non-owner's rsp_ready SHALL be ignored; rsp_ready is ignored outside RESP.
REQ-013 alu_a, alu_b and alu_func SHALL always reflect the latched registers, including in IDLE and RESP.
REQ-014 rsp_result SHALL always equal the result register, including when rsp_valid is 0.
REQ-015 SHALL not check or alter func codes; an unknown code yields whatever the ALU returns.
REQ-016 The arbiter SHALL keep a 1-bit last_grant register, updated on every accept to the accepted requester's id.

Reset
REQ-017 When rst=1 at a clock edge, SHALL set state=IDLE, last_grant=1 (so requester 0 wins first), and clear all latched operand, func, owner and result registers to 0.
REQ-018 During and after reset, all req_ready, rsp_valid, busy and alu_* outputs SHALL be 0.
REQ-019 Reset asserted in EXEC or RESP SHALL drop the in-flight operation with no response; the next cycle is IDLE.

Configuration
REQ-020 Macro YSYX_ALU_ARB_RR_EN defined: when both requesters are valid in IDLE, SHALL grant the requester not equal to last_grant (round-robin).
REQ-021 Macro YSYX_ALU_ARB_RR_EN undefined: SHALL use fixed priority, requester 0 always wins a tie; last_grant is still maintained but does not affect the grant.
REQ-022 A lone valid requester SHALL be granted immediately in both configurations.

Verification
REQ-023 Requester 0 sends ADD (func 0000), 5 and 7, with rsp_ready_0=1 -> rsp_valid_0 high at T+2, rsp_result=12, busy low at T+3.
REQ-024 Requester 1 sends SRA (func 1101), 0x80000000 by 4 -> rsp_valid_1 with rsp_result=0xF8000000; rsp_valid_0 stays 0.
REQ-025 With RR_EN, both valid continuously after reset, each op distinct -> grant order 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-026 In RESP, owner rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_result stable, req_ready_0/1 stay 0, accept occurs only after the handshake.
REQ-027 rst pulsed for one cycle while in EXEC -> no rsp_valid; the next cycle is IDLE with busy=0; a pending request is then granted normally.
